set_assoc_cache_ctrl: RTL and testbench

Parametrised, single-port cache controller that generalises the L1/L2/L3 configuration into one module. Associativity, set count, block size and write policy are all set by parameters. It sits between the processor request port and the next level: a lower cache instance or main memory, moved one whole block per transfer. It implements hit/miss lookup, true-LRU replacement, write-back or write-through, write-allocate, and hit/miss statistics counters.

---
 rtl/set_assoc_cache_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_ctrl.sv
// Parametrised single-port set-associative cache controller.
// Looks up processor requests, refills/evicts whole blocks from the next
// level, keeps true-LRU ages per set and counts hits and misses.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The side raising valid keeps it and all payload fields stable
// until that edge. It drops valid in the cycle that follows unless it has
// another transfer. mem_resp_valid is a single-cycle pulse that needs no
// ready. It is only looked at after this controller's next-level request
// has been accepted.
module set_assoc_cache_ctrl #(
  parameter int ASSOC           = 4,
  parameter int NUM_SETS        = 4,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WRITE_POLICY    = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [ADDRESS_WIDTH-1:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]                 req_wdata,
  output logic                                  resp_valid,
  output logic [DATA_WIDTH-1:0]                 resp_rdata,
  output logic                                  mem_req_valid,
  input  logic                                  mem_req_ready,
  output logic                                  mem_we,
  output logic [ADDRESS_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic                                  mem_resp_valid,
  input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_rdata,
  output logic [31:0]                           hit_cnt,
  output logic [31:0]                           miss_cnt
);
  localparam int OFF_BITS = 2 + $clog2(WORDS_PER_BLOCK);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_LSB  = OFF_BITS + IDX_BITS;
  localparam int TAG_W    = ADDRESS_WIDTH - TAG_LSB;
  localparam int SET_W    = (NUM_SETS > 1) ? IDX_BITS : 1;
  localparam int WRD_W    = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int WAY_W    = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam int BLK_W    = DATA_WIDTH * WORDS_PER_BLOCK;
  localparam bit WB       = (WRITE_POLICY == 1);
  localparam logic [ADDRESS_WIDTH-1:0] BLK_MASK = {ADDRESS_WIDTH{1'b1}} << OFF_BITS;
  localparam logic [ADDRESS_WIDTH-1:0] IDX_MASK = BLK_MASK & ~({ADDRESS_WIDTH{1'b1}} << TAG_LSB);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, WTHRU, RESPOND} state_t;
  state_t state, state_nx;

  // Line storage; only valid, dirty and age are cleared by reset.
  logic             valid_a [NUM_SETS][ASSOC];
  logic             dirty_a [NUM_SETS][ASSOC];
  logic [TAG_W-1:0] tag_a   [NUM_SETS][ASSOC];
  logic [BLK_W-1:0] data_a  [NUM_SETS][ASSOC];
  logic [WAY_W-1:0] age_a   [NUM_SETS][ASSOC];

  logic                     r_we, req_done;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata, rdata_q;
  logic [WAY_W-1:0]         way_q, hit_way, inv_way, lru_way, victim_way, touch_way;
  logic [SET_W-1:0]         set_idx;
  logic [WRD_W-1:0]         req_word;
  logic [TAG_W-1:0]         req_tag;
  logic                     hit, found_inv, mem_done, touch_en;
  logic [BLK_W-1:0]         cur_line;

  assign set_idx  = SET_W'((r_addr >> OFF_BITS) & ADDRESS_WIDTH'(NUM_SETS - 1));
  assign req_word = WRD_W'((r_addr >> 2) & ADDRESS_WIDTH'(WORDS_PER_BLOCK - 1));
  assign req_tag  = TAG_W'(r_addr >> TAG_LSB);
  assign cur_line = data_a[set_idx][way_q];
  assign mem_done = req_done && mem_resp_valid;
  assign resp_rdata = rdata_q;

  function automatic logic [DATA_WIDTH-1:0] get_word(input logic [BLK_W-1:0] blk,
                                                     input logic [WRD_W-1:0] w);
    get_word = blk[w*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk,
                                                input logic [WRD_W-1:0] w,
                                                input logic [DATA_WIDTH-1:0] d);
    put_word = blk;
    put_word[w*DATA_WIDTH +: DATA_WIDTH] = d;
  endfunction

  // Tag compare across the set, plus victim choice (first invalid way, else oldest).
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (valid_a[set_idx][w] && (tag_a[set_idx][w] == req_tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_a[set_idx][w] && !found_inv) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_a[set_idx][w] == WAY_W'(ASSOC - 1)) lru_way = WAY_W'(w);
    end
    victim_way = found_inv ? inv_way : lru_way;
    touch_en   = ((state == LOOKUP) && hit) || ((state == REFILL) && mem_done);
    touch_way  = (state == LOOKUP) ? hit_way : way_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and port outputs; next-level fields are held while not yet accepted.
  always_comb begin
    state_nx      = state;
    req_ready     = (state == IDLE);
    resp_valid    = (state == RESPOND);
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      IDLE:      if (req_valid) state_nx = LOOKUP;
      LOOKUP: begin
        if (hit)
          state_nx = (r_we && !WB) ? WTHRU : RESPOND;
        else if (WB && valid_a[set_idx][victim_way] && dirty_a[set_idx][victim_way])
          state_nx = WRITEBACK;
        else
          state_nx = REFILL;
      end
      WRITEBACK: begin
        mem_req_valid = !req_done;
        mem_we        = !req_done;
        mem_addr      = req_done ? '0 :
                        ((ADDRESS_WIDTH'(tag_a[set_idx][way_q]) << TAG_LSB) | (r_addr & IDX_MASK));
        mem_wdata     = req_done ? '0 : cur_line;
        if (mem_done) state_nx = REFILL;
      end
      REFILL: begin
        mem_req_valid = !req_done;
        mem_addr      = req_done ? '0 : (r_addr & BLK_MASK);
        if (mem_done) state_nx = (r_we && !WB) ? WTHRU : RESPOND;
      end
      WTHRU: begin
        mem_req_valid = !req_done;
        mem_we        = !req_done;
        mem_addr      = req_done ? '0 : (r_addr & BLK_MASK);
        mem_wdata     = req_done ? '0 : cur_line;
        if (mem_done) state_nx = RESPOND;
      end
      RESPOND:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Request latch, line updates, LRU ages, handshake phase and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      rdata_q  <= '0;
      way_q    <= '0;
      req_done <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < ASSOC; w++) begin
          valid_a[s][w] <= 1'b0;
          dirty_a[s][w] <= 1'b0;
          age_a[s][w]   <= WAY_W'(w);
        end
    end else begin
      if (mem_req_valid && mem_req_ready) req_done <= 1'b1;
      if (mem_done)                       req_done <= 1'b0;
      if (touch_en) begin
        for (int w = 0; w < ASSOC; w++)
          if (age_a[set_idx][w] < age_a[set_idx][touch_way])
            age_a[set_idx][w] <= age_a[set_idx][w] + 1'b1;
        age_a[set_idx][touch_way] <= '0;
      end
      case (state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            way_q <= hit_way;
            if (r_we) begin
              data_a[set_idx][hit_way] <= put_word(data_a[set_idx][hit_way], req_word, r_wdata);
              if (WB) dirty_a[set_idx][hit_way] <= 1'b1;
              rdata_q <= r_wdata;
            end else begin
              rdata_q <= get_word(data_a[set_idx][hit_way], req_word);
            end
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            way_q <= victim_way;
          end
        end
        REFILL: if (mem_done) begin
          valid_a[set_idx][way_q] <= 1'b1;
          tag_a[set_idx][way_q]   <= req_tag;
          dirty_a[set_idx][way_q] <= r_we && WB;
          data_a[set_idx][way_q]  <= r_we ? put_word(mem_rdata, req_word, r_wdata) : mem_rdata;
          rdata_q                 <= r_we ? r_wdata : get_word(mem_rdata, req_word);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Bench for set_assoc_cache_ctrl: three instances (write-back 4-way,
// write-through 4-way, write-back direct-mapped) exercised one after another
// against a reference model of LRU-ordered sets and a word-level golden memory.
module tb_set_assoc_cache_ctrl;
  localparam int BW = 128;
  localparam int CW = 1 + 32 + BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic          mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [BW-1:0] mem_rdata = '0;
  int            cur = 0;

  wire          rv_a [3];
  wire          ready_a [3], resp_v_a [3], mreq_v_a [3], mwe_a [3];
  wire [31:0]   rdata_a [3], maddr_a [3], hit_a [3], miss_a [3];
  wire [BW-1:0] mwdata_a [3];

  assign rv_a[0] = req_valid && (cur == 0);
  assign rv_a[1] = req_valid && (cur == 1);
  assign rv_a[2] = req_valid && (cur == 2);

  logic req_ready, resp_valid, mem_req_valid, mem_we;
  logic [31:0] resp_rdata, mem_addr, hit_cnt, miss_cnt;
  logic [BW-1:0] mem_wdata;

  // Route the outputs of the instance under test to common names.
  always_comb begin
    req_ready     = ready_a[cur];
    resp_valid    = resp_v_a[cur];
    mem_req_valid = mreq_v_a[cur];
    mem_we        = mwe_a[cur];
    resp_rdata    = rdata_a[cur];
    mem_addr      = maddr_a[cur];
    hit_cnt       = hit_a[cur];
    miss_cnt      = miss_a[cur];
    mem_wdata     = mwdata_a[cur];
  end

  set_assoc_cache_ctrl #(.ASSOC(4), .WRITE_POLICY(1)) dut_wb (
    .clk(clk), .reset(reset), .req_valid(rv_a[0]), .req_ready(ready_a[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_v_a[0]), .resp_rdata(rdata_a[0]),
    .mem_req_valid(mreq_v_a[0]), .mem_req_ready(mem_req_ready), .mem_we(mwe_a[0]),
    .mem_addr(maddr_a[0]), .mem_wdata(mwdata_a[0]), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .hit_cnt(hit_a[0]), .miss_cnt(miss_a[0]));

  set_assoc_cache_ctrl #(.ASSOC(4), .WRITE_POLICY(0)) dut_wt (
    .clk(clk), .reset(reset), .req_valid(rv_a[1]), .req_ready(ready_a[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_v_a[1]), .resp_rdata(rdata_a[1]),
    .mem_req_valid(mreq_v_a[1]), .mem_req_ready(mem_req_ready), .mem_we(mwe_a[1]),
    .mem_addr(maddr_a[1]), .mem_wdata(mwdata_a[1]), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .hit_cnt(hit_a[1]), .miss_cnt(miss_a[1]));

  set_assoc_cache_ctrl #(.ASSOC(1), .WRITE_POLICY(1)) dut_dm (
    .clk(clk), .reset(reset), .req_valid(rv_a[2]), .req_ready(ready_a[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_v_a[2]), .resp_rdata(rdata_a[2]),
    .mem_req_valid(mreq_v_a[2]), .mem_req_ready(mem_req_ready), .mem_we(mwe_a[2]),
    .mem_addr(maddr_a[2]), .mem_wdata(mwdata_a[2]), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .hit_cnt(hit_a[2]), .miss_cnt(miss_a[2]));

  // ---------------- scoreboard / reference model ----------------
  int checks = 0, errors = 0;
  int assoc_p [3] = '{4, 4, 1};
  int wp_p    [3] = '{1, 0, 1};

  logic [31:0]   lru_q [4][$];              // per set, block addresses, most recent first
  bit            dirty_m [logic [31:0]];    // blocks the model holds dirty
  logic [31:0]   gold [logic [31:0]];       // latest stored value per word address
  logic [BW-1:0] back_m [logic [31:0]];     // next-level memory contents per block
  logic [CW-1:0] exp_q [$];                 // expected next-level transfers {we, addr, data}
  int            m_hits, m_misses;
  bit            exp_hit;
  logic [31:0]   exp_rdata;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (instance %0d, t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hAAAA0000 ^ ((a - 32'h40) * 32'h01000193);
  endfunction

  function automatic logic [BW-1:0] rd_block(input logic [31:0] blk);
    logic [BW-1:0] b;
    if (back_m.exists(blk)) return back_m[blk];
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = init_word(blk + 32'(4 * i));
    return b;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [BW-1:0] b;
    logic [31:0]   al;
    al = a & ~32'h3;
    if (gold.exists(al)) return gold[al];
    b = rd_block(al & ~32'hF);
    return b[al[3:2]*32 +: 32];
  endfunction

  function automatic logic [BW-1:0] gold_block(input logic [31:0] blk);
    logic [BW-1:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = gold_word(blk + 32'(4 * i));
    return b;
  endfunction

  // Dirty data that was never written back is lost on reset.
  function automatic void model_reset();
    foreach (dirty_m[b]) for (int i = 0; i < 4; i++) gold.delete(b + 32'(4 * i));
    dirty_m.delete();
    for (int s = 0; s < 4; s++) lru_q[s].delete();
    exp_q.delete();
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic void model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] blk, victim;
    int set, pos;
    blk = addr & ~32'hF;
    set = int'((addr >> 4) & 32'h3);
    pos = -1;
    foreach (lru_q[set][i]) if (lru_q[set][i] == blk) pos = i;
    exp_hit = (pos >= 0);
    if (exp_hit) begin
      m_hits++;
      lru_q[set].delete(pos);
    end else begin
      m_misses++;
      if (lru_q[set].size() == assoc_p[cur]) begin
        victim = lru_q[set].pop_back();
        if (wp_p[cur] == 1 && dirty_m.exists(victim)) exp_q.push_back({1'b1, victim, gold_block(victim)});
        dirty_m.delete(victim);
      end
      exp_q.push_back({1'b0, blk, {BW{1'b0}}});
    end
    lru_q[set].push_front(blk);
    if (we) begin
      gold[addr & ~32'h3] = wd;
      if (wp_p[cur] == 1) dirty_m[blk] = 1'b1;
      else exp_q.push_back({1'b1, blk, gold_block(blk)});
      exp_rdata = wd;
    end else begin
      exp_rdata = gold_word(addr);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", CW'(req_ready), CW'(1));
    check("rst_resp_valid", CW'(resp_valid), CW'(0));
    check("rst_mem_req_valid", CW'(mem_req_valid), CW'(0));
    check("rst_mem_fields", CW'({mem_we, mem_addr, resp_rdata}), CW'(0));
    check("rst_counters", CW'({hit_cnt, miss_cnt}), CW'(0));
    reset = 1'b0;
    model_reset();
  endtask

  // One processor request with a randomly-timed next level; 'stall' forces
  // that many cycles of mem_req_ready=0 on the first next-level request.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    logic [CW-1:0] got_q [$];
    logic [CW-1:0] seen, now_t;
    logic [31:0]   rd_addr;
    bit            have_seen, done, last_rd;
    int            phase, dly, cyc, resp_cyc, resp_cnt, stall_left;
    model_access(we, addr, wdata);
    @(negedge clk);
    check("idle_ready", CW'(req_ready), CW'(1));
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom();
    have_seen = 1'b0; done = 1'b0; phase = 0; dly = 0; cyc = 1;
    resp_cyc = 0; resp_cnt = 0; stall_left = stall; last_rd = 1'b0; rd_addr = '0;
    while (!done && cyc < 300) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (resp_valid) begin
        resp_cnt++;
        resp_cyc = cyc;
        check("resp_rdata", CW'(resp_rdata), CW'(exp_rdata));
        done = 1'b1;
      end
      if (phase == 2) phase = 0;
      if (phase == 1) begin
        if (dly == -1) check("mem_valid_drop", CW'(mem_req_valid), CW'(0));
        if (dly <= 0) begin
          mem_resp_valid = 1'b1;
          if (last_rd) mem_rdata = rd_block(rd_addr);
          phase = 2;
        end else dly--;
      end else if (phase == 0 && mem_req_valid) begin
        now_t = {mem_we, mem_addr, mem_we ? mem_wdata : {BW{1'b0}}};
        if (!have_seen) begin
          seen = now_t;
          have_seen = 1'b1;
        end else begin
          check("mem_stable", now_t, seen);
        end
        check("busy_not_ready", CW'({req_ready, resp_valid}), CW'(0));
        if (stall_left > 0) stall_left--;
        else if ($urandom_range(0, 2) != 0) begin
          mem_req_ready = 1'b1;
          got_q.push_back(seen);
          last_rd = !mem_we;
          rd_addr = mem_addr;
          if (mem_we) back_m[mem_addr] = mem_wdata;
          have_seen = 1'b0;
          phase = 1;
          dly = -int'($urandom_range(0, 2)) - 1;
          dly = (dly == -1) ? -1 : -dly - 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    if (!done) begin
      check("resp_timeout", CW'(0), CW'(1));
    end else begin
      if (exp_hit && !(we && wp_p[cur] == 0)) check("hit_latency", CW'(resp_cyc), CW'(2));
      check("resp_pulse_once", CW'(resp_cnt), CW'(1));
      check("ready_after_resp", CW'({req_ready, resp_valid}), CW'(2'b10));
    end
    check("mem_txn_count", CW'(got_q.size()), CW'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check("mem_txn", got_q[i], exp_q[i]);
    exp_q.delete();
    check("hit_cnt", CW'(hit_cnt), CW'(m_hits));
    check("miss_cnt", CW'(miss_cnt), CW'(m_misses));
  endtask

  task automatic reset_mid_refill(input logic [31:0] addr);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_refill_req", CW'({mem_req_valid, mem_we, mem_addr}), CW'({1'b1, 1'b0, addr & ~32'hF}));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_mem_valid", CW'(mem_req_valid), CW'(0));
    check("mid_rst_ready", CW'({req_ready, resp_valid}), CW'(2'b10));
    check("mid_rst_counters", CW'({hit_cnt, miss_cnt}), CW'(0));
    model_reset();
  endtask

  task automatic random_reqs(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      do_req($urandom_range(0, 4) < 2, a, $urandom(), ($urandom_range(0, 9) == 0) ? 3 : 0);
    end
  endtask

  function automatic void new_instance(input int idx);
    cur = idx;
    back_m.delete();
    gold.delete();
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    // write-back, 4-way
    new_instance(0);
    do_reset();
    reset_mid_refill(32'h40);
    do_req(1'b0, 32'h40, 32'h0, 0);
    check("first_load_word0", CW'(resp_rdata), CW'(32'hAAAA0000));
    do_req(1'b0, 32'h40, 32'h0, 0);
    do_req(1'b1, 32'h40, 32'h12345678, 0);
    do_req(1'b0, 32'h80, 32'h0, 0);
    do_req(1'b0, 32'hC0, 32'h0, 0);
    do_req(1'b0, 32'h100, 32'h0, 0);
    do_req(1'b0, 32'h140, 32'h0, 0);
    do_req(1'b0, 32'h180, 32'h0, 5);
    random_reqs(150);

    // write-through, 4-way
    new_instance(1);
    do_reset();
    do_req(1'b0, 32'h40, 32'h0, 0);
    do_req(1'b1, 32'h40, 32'hDEADBEEF, 0);
    do_req(1'b0, 32'h80, 32'h0, 0);
    do_req(1'b0, 32'hC0, 32'h0, 0);
    do_req(1'b0, 32'h100, 32'h0, 0);
    do_req(1'b0, 32'h140, 32'h0, 0);
    do_req(1'b0, 32'h44, 32'h0, 2);
    random_reqs(150);

    // direct-mapped, write-back
    new_instance(2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 32'h40, 32'h0, 0);
      do_req(1'b0, 32'h140, 32'h0, 0);
    end
    check("dm_miss_total", CW'(miss_cnt), CW'(8));
    check("dm_hit_total", CW'(hit_cnt), CW'(0));
    random_reqs(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
